// File: rtl/dbm_memrd_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ks10_memrd_pkg
// Brief   : Shared state encoding and timer constants for the DBM memory-read
//           sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package ks10_memrd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int c_nxm_timeout_dflt = 255;
  localparam int c_timer_w          = 8;

endpackage
`default_nettype wire

// File: rtl/dbm_memrd_ctl_nxm_timer.sv
`default_nettype none
// ============================================================================
// Module  : memrd_nxm_timer
// Brief   : Counts cycles of an outstanding read and flags the timeout cycle.
// Revision: 1.0 - initial release
// ============================================================================
module memrd_nxm_timer
  import ks10_memrd_pkg::*;
#(
  parameter int NXM_TIMEOUT = c_nxm_timeout_dflt
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  logic [c_timer_w-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_count <= '0;
    else if (clear)  r_count <= '0;
    else if (run)    r_count <= r_count + 1'b1;
  end

  // Fires in the cycle whose closing edge would bring the count to NXM_TIMEOUT.
  assign expire = run && (r_count == c_timer_w'(NXM_TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/dbm_memrd_ctl.sv
`default_nettype none
// ============================================================================
// Module  : dbm_memrd_ctl
// Brief   : Memory-read sequencer feeding the DBM MEM source; optional NXM
//           timeout enabled by macro KS10_MEMRD_NXM_EN.
// Revision: 1.0 - initial release
// ============================================================================
module dbm_memrd_ctl
  import ks10_memrd_pkg::*;
#(
  parameter int NXM_TIMEOUT = c_nxm_timeout_dflt
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memREQ,
  input  logic        memABORT,
  input  logic        busGRANT,
  input  logic        busDATAV,
  input  logic [35:0] busDATAI,
  input  logic        nxmCLR,
  output logic        busREQ,
  output logic [35:0] memDATA,
  output logic        memBUSY,
  output logic        memDONE,
  output logic        memNXM
);

  state_t      r_state;
  state_t      w_next;
  logic        w_load;
  logic        w_nxm_load;
  logic        w_start;
  logic        w_expire;
  logic [35:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Abort outranks data, grant and timeout; data outranks timeout.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_nxm_load = 1'b0;
    w_start    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (memREQ && !memABORT) begin
          w_next  = S_REQ;
          w_start = 1'b1;
        end
      end
      S_REQ: begin
        if (memABORT) begin
          w_next = S_IDLE;
        end else if (busGRANT && busDATAV) begin
          w_next = S_DONE;
          w_load = 1'b1;
        end else if (w_expire) begin
          w_next     = S_DONE;
          w_nxm_load = 1'b1;
        end else if (busGRANT) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (memABORT) begin
          w_next = S_IDLE;
        end else if (busDATAV) begin
          w_next = S_DONE;
          w_load = 1'b1;
        end else if (w_expire) begin
          w_next     = S_DONE;
          w_nxm_load = 1'b1;
        end
      end
      S_DONE: begin
        if (memREQ && !memABORT) begin
          w_next  = S_REQ;
          w_start = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_data <= '0;
    else if (w_load)     r_data <= busDATAI;
    else if (w_nxm_load) r_data <= '0;
  end

  assign memDATA = r_data;
  assign memBUSY = (r_state == S_REQ) || (r_state == S_WAIT);
  assign busREQ  = memBUSY;
  assign memDONE = (r_state == S_DONE);

`ifdef KS10_MEMRD_NXM_EN
  logic r_nxm;

  memrd_nxm_timer #(
    .NXM_TIMEOUT (NXM_TIMEOUT)
  ) u_nxm_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_start),
    .run    (memBUSY),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_nxm <= 1'b0;
    else if (w_nxm_load) r_nxm <= 1'b1;
    else if (nxmCLR)     r_nxm <= 1'b0;
  end

  assign memNXM = r_nxm;
`else
  logic w_unused;

  assign w_expire = 1'b0;
  assign memNXM   = 1'b0;
  assign w_unused = nxmCLR ^ (NXM_TIMEOUT == 0);
`endif

endmodule
`default_nettype wire

// File: doc/dbm_memrd_ctl.md
# dbm_memrd_ctl

Memory-read sequencer that owns the MEM source of the CPU DBM multiplexer. It accepts a read request from microcode decode, arbitrates for the memory bus, and waits for read data. It captures the data into a 36-bit holding register that drives the DBM MEM input, and stalls the microsequencer while the read is outstanding. Optional non-existent-memory (NXM) timeout detection reports reads that never complete.

## Interface
Parameters:
- NXM_TIMEOUT, 255: cycles from request acceptance to NXM declaration; legal range 2..255.

Ports:
- clk  in  1  CPU clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- memREQ  in  1  microcode read request; single-cycle level, sampled each cycle.
- memABORT  in  1  page-fail/abort; cancels any outstanding read.
- busGRANT  in  1  bus arbiter grant for busREQ.
- busDATAV  in  1  read data valid strobe.
- busDATAI  in  36  memory bus data, bits [0:35].
- nxmCLR  in  1  clears sticky memNXM.
- busREQ  out  1  bus request to arbiter.
- memDATA  out  36  holding register feeding DBM MEM source.
- memBUSY  out  1  stall to microsequencer.
- memDONE  out  1  one-cycle pulse: memDATA newly loaded.
- memNXM  out  1  sticky NXM flag.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: memREQ=1 → REQ. busDATAV and busGRANT are ignored.
- REQ: busREQ=1.
  - busGRANT=1, busDATAV=0 → WAIT.
  - busGRANT=1 and busDATAV=1 in the same cycle → latch busDATAI, go to DONE.
- WAIT: busREQ remains 1. busDATAV=1 → latch busDATAI into memDATA, go to DONE.
- DONE: memDONE=1 for this cycle. memREQ=1 → REQ (back-to-back read); otherwise → IDLE.
- memREQ in REQ or WAIT is ignored. No queueing; microcode must not issue it while memBUSY=1.
- memABORT=1 in REQ or WAIT → IDLE next cycle. busREQ drops, memDATA is unchanged, no memDONE.
- memABORT has priority over busDATAV, busGRANT and memREQ in the same cycle. memABORT in IDLE or DONE has no effect beyond suppressing a memREQ in that cycle.
- memBUSY=1 exactly when state is REQ or WAIT.
- memDATA holds its value until the next successful latch. It is never cleared except by reset or an NXM load.

## Timing
- Reset: state IDLE, busREQ=0, memDATA=36'o0, memBUSY=0, memDONE=0, memNXM=0, timer=0.
- memREQ sampled at edge 0 → busREQ and memBUSY high after edge 0 (cycle 1).
- busDATAV sampled at edge n → after edge n: memDATA valid, memDONE=1, memBUSY=0.
- Minimum latency: memREQ at edge 0, busGRANT and busDATAV at edge 1 → memDONE in cycle 2.
- Back-to-back minimum: memDONE every 2 cycles.

## Configuration
- Macro KS10_MEMRD_NXM_EN.
- Defined:
  - An 8-bit timer clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the timer reaches NXM_TIMEOUT without busDATAV: memDATA←0, memNXM←1, memDONE pulses, state → DONE.
  - busDATAV in the timeout cycle wins: data is latched and no NXM is flagged.
  - nxmCLR clears memNXM; a new NXM set in the same cycle wins over nxmCLR.
- Undefined: no timer; WAIT/REQ wait indefinitely; memNXM tied 0; nxmCLR ignored.

## Structure
- Package ks10_memrd_pkg holds:
  - the state enumeration (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3);
  - the default NXM_TIMEOUT constant;
  - the timer width constant (8).
- Sub-module memrd_nxm_timer, present only under KS10_MEMRD_NXM_EN.
  - Inputs: clk, rst_n, clear, run.
  - Output: expire.

## Test plan
- Reset mid-WAIT, rst_n low → all outputs at reset values immediately; state IDLE after rst_n high.
- memREQ at edge 0, busGRANT at edge 2, busDATAV with busDATAI=36'o123456701234 at edge 4 → busREQ high cycles 1–4; memDONE and memDATA=36'o123456701234 in cycle 5; memBUSY low in cycle 5.
- memREQ, then busGRANT and busDATAV in the same cycle (edge 1) with data 36'o777777777777 → memDONE in cycle 2. Then memREQ in DONE → busREQ high again in cycle 3.
- memABORT in WAIT coincident with busDATAV (data 36'o1) → IDLE, memDATA unchanged, no memDONE.
- KS10_MEMRD_NXM_EN, NXM_TIMEOUT=4, grant but no data → memNXM=1, memDATA=0, memDONE in cycle 5. nxmCLR then clears memNXM.
- KS10_MEMRD_NXM_EN undefined, no busDATAV for 1000 cycles → memBUSY stays 1, memNXM stays 0.
